serial_mp_adder_ctrl: RTL and testbench

Multi-precision adder sequencer. It accepts NBYTES-wide operands and streams them one byte per cycle through a single shared 8-bit adder stage ({cout,sum} = a + b + cin), chaining the carry through a register. It replaces a wide combinational adder with a start/ready/done controller, so the wide add costs NBYTES+1 cycles instead of wide-adder area.

---
 rtl/serial_mp_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_mp_adder_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mp_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_mp_adder_ctrl
// Purpose  : Multi-precision adder sequencer. Wide operands are latched on a
//            start/ready handshake, then added one byte per cycle through a
//            single 8-bit adder stage with the carry chained in a register.
//            A one-cycle done pulse marks the registered result as valid.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            start  - request, accepted only while ready=1
//            a, b   - W-bit operands (W = 8*NBYTES), sampled on accept
//            cin    - carry into byte 0, sampled on accept
//            sub    - (ADD_SUB_EN only) 1 = compute a-b, sampled on accept
//            ready  - high in IDLE
//            busy   - high in ADD
//            done   - one-cycle result-valid pulse
//            sum    - W-bit registered result (modulo 2^W)
//            cout   - registered carry out of the top byte
// Options  : define ADD_SUB_EN to add the sub port and subtract mode.
// Revision : 1.0 - initial release
// ============================================================================
module serial_mp_adder_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   a,
   input  logic [8*NBYTES-1:0]   b,
   input  logic                  cin,
`ifdef ADD_SUB_EN
   input  logic                  sub,
`endif
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   sum,
   output logic                  cout
);

   localparam int c_w     = 8 * NBYTES;
   localparam int c_idx_w = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [c_w-1:0]      a_q, a_d;
   logic [c_w-1:0]      b_q, b_d;
   logic                carry_q, carry_d;
   logic [c_idx_w-1:0]  idx_q, idx_d;
   logic [c_w-1:0]      sum_q, sum_d;
   logic                cout_q, cout_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // Shared byte-wide adder stage
   logic [7:0]          a_byte;
   logic [7:0]          b_byte;
   logic [8:0]          byte_sum;

   assign a_byte   = a_q[8*idx_q +: 8];
   assign b_byte   = b_q[8*idx_q +: 8];
   assign byte_sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
`ifdef ADD_SUB_EN
               // Two's-complement subtract: a + ~b + 1, cin ignored
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
               idx_d   = '0;
               state_d = S_ADD;
            end
         end

         S_ADD: begin
            sum_d[8*idx_q +: 8] = byte_sum[7:0];
            carry_d             = byte_sum[8];
            if (idx_q == c_last_idx) begin
               // Index stays at NBYTES-1; it is reloaded on the next accept
               cout_d  = byte_sum[8];
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next-state decode
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d == S_ADD);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign ready = ready_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign sum   = sum_q;
   assign cout  = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mp_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_mp_adder_ctrl
// Purpose  : Self-checking bench for serial_mp_adder_ctrl (NBYTES=4).
//            Directed vector table, randomized operations against an
//            arithmetic reference model, and hand-written sequences for
//            held start, operand isolation and mid-operation reset.
//            Subtract checks are included when ADD_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_mp_adder_ctrl;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          sub;
   logic          ready;
   logic          busy;
   logic          done;
   logic [W-1:0]  sum;
   logic          cout;

   int n_pass;
   int n_total;

   serial_mp_adder_ctrl #(.NBYTES(NBYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef ADD_SUB_EN
      .sub   (sub),
`endif
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Reference: plain wide arithmetic, result is {cout, sum}
   function automatic logic [W:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                        input logic tc, input logic ts);
      logic [W:0] r;
      if (ts) begin
         r[W-1:0] = ta - tb;
         r[W]     = (ta >= tb);
      end else begin
         r = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
      end
      return r;
   endfunction

   // One complete operation: handshake, latency, busy length, result, done pulse
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts, input bit scramble, input logic [W:0] exp, input string tag);
      int lat;
      int nbusy;
      @(negedge clk);
      a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
      check({tag, " ready before accept"}, {63'd0, ready}, 64'd1);
      @(negedge clk);
      start = 1'b0;
      lat   = 1;
      nbusy = 0;
      while (!done && lat < 50) begin
         if (busy) nbusy++;
         if (scramble) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check({tag, " done seen"},      {63'd0, done}, 64'd1);
      check({tag, " latency"},        64'(lat), 64'(NBYTES + 1));
      check({tag, " busy cycles"},    64'(nbusy), 64'(NBYTES));
      check({tag, " sum"},            64'(sum), 64'(exp[W-1:0]));
      check({tag, " cout"},           {63'd0, cout}, {63'd0, exp[W]});
      check({tag, " ready in done"},  {63'd0, ready}, 64'd0);
      @(negedge clk);
      check({tag, " done one cycle"}, {63'd0, done}, 64'd0);
      check({tag, " ready after"},    {63'd0, ready}, 64'd1);
      check({tag, " sum held"},       64'(sum), 64'(exp[W-1:0]));
   endtask

   vec_t vecs [4];

   initial begin
      int ndone;
      int first_k;
      int second_k;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;

      n_pass  = 0;
      n_total = 0;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      vecs[0] = '{a: 32'h12345678, b: 32'h11111111, cin: 1'b0, sub: 1'b0, exp_sum: 32'h23456789, exp_cout: 1'b0};
      vecs[1] = '{a: 32'hFFFFFFFF, b: 32'h00000001, cin: 1'b0, sub: 1'b0, exp_sum: 32'h00000000, exp_cout: 1'b1};
      vecs[2] = '{a: 32'h000000FF, b: 32'h00000000, cin: 1'b1, sub: 1'b0, exp_sum: 32'h00000100, exp_cout: 1'b0};
      vecs[3] = '{a: 32'h80000000, b: 32'h80000000, cin: 1'b1, sub: 1'b0, exp_sum: 32'h00000001, exp_cout: 1'b1};

      // Reset state
      #12;
      check("reset ready", {63'd0, ready}, 64'd1);
      check("reset busy",  {63'd0, busy},  64'd0);
      check("reset done",  {63'd0, done},  64'd0);
      check("reset sum",   64'(sum),       64'd0);
      check("reset cout",  {63'd0, cout},  64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 4; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0,
                {vecs[i].exp_cout, vecs[i].exp_sum}, $sformatf("vec%0d", i));

      // Operand isolation: inputs scrambled during ADD
      run_op(32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b1, {1'b0, 32'h00000100}, "isolation");

      // Start held high: two ops, exactly two done pulses NBYTES+2 apart
      @(negedge clk);
      a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; start = 1'b1;
      ndone = 0; first_k = -1; second_k = -1;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         if (k == 0) begin a = 32'h3; b = 32'h4; end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               first_k = k;
               check("held first sum", 64'(sum), 64'h3);
            end else if (ndone == 2) begin
               second_k = k;
               check("held second sum", 64'(sum), 64'h7);
            end
         end
         if (ndone == 1 && busy) start = 1'b0;
      end
      start = 1'b0;
      check("held done count",   64'(ndone), 64'd2);
      check("held done spacing", 64'(second_k - first_k), 64'(NBYTES + 2));

      // Asynchronous reset in the middle of ADD
      @(negedge clk);
      a = 32'hFFFFFFFF; b = 32'h1; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst ready", {63'd0, ready}, 64'd1);
      check("midrst busy",  {63'd0, busy},  64'd0);
      check("midrst done",  {63'd0, done},  64'd0);
      check("midrst sum",   64'(sum),       64'd0);
      check("midrst cout",  {63'd0, cout},  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst no done", 64'(ndone), 64'd0);
      run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b0, {1'b0, 32'h23456789}, "post reset");

`ifdef ADD_SUB_EN
      run_op(32'h5, 32'h7, 1'b0, 1'b1, 1'b0, {1'b0, 32'hFFFFFFFE}, "sub 5-7");
      run_op(32'h7, 32'h5, 1'b1, 1'b1, 1'b0, {1'b1, 32'h00000002}, "sub 7-5");
`endif

      // Randomized operations against the reference model
      for (int i = 0; i < 30; i++) begin
         ra = W'($urandom);
         rb = (i % 5 == 0) ? ~ra : W'($urandom);
         rc = 1'($urandom);
`ifdef ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rc, rs, (i % 2 == 1), model(ra, rb, rc, rs), $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
